// File: rtl/io_sequencer_pkg.sv
// Shared types and constants for the IN/OUT I/O sequencer.
package io_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RELEASE,
        WAIT_PRESS,
        CAPTURE
    } io_state_t;

    localparam int unsigned IO_WORD     = 32;
    localparam int unsigned SW_DEFAULT  = 17;
    localparam int unsigned ZEXT_WIDTH  = IO_WORD - SW_DEFAULT;

endpackage

// File: rtl/io_sequencer_if.sv
// Bundle between the control unit / board I/O and the I/O sequencer.
interface io_sequencer_if #(
    parameter int unsigned SW_WIDTH = io_pkg::SW_DEFAULT
);
    import io_pkg::*;

    logic                 in_req;
    logic                 out_req;
    logic [SW_WIDTH-1:0]  switches;
    logic                 btn_enter;
    logic [IO_WORD-1:0]   out_data;
    logic                 stall;
    logic                 sel_in;
    logic [IO_WORD-1:0]   in_data;
    logic                 reg_write_in;
    logic [IO_WORD-1:0]   display;
    logic                 display_valid;
    logic                 waiting;

    modport master (
        output in_req, out_req, switches, btn_enter, out_data,
        input  stall, sel_in, in_data, reg_write_in, display, display_valid, waiting
    );

    modport slave (
        input  in_req, out_req, switches, btn_enter, out_data,
        output stall, sel_in, in_data, reg_write_in, display, display_valid, waiting
    );

endinterface

// File: rtl/io_sequencer_btn_debouncer.sv
// Enter-button conditioning: 2-flop synchronizer, level debouncer and press pulse.
module btn_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int unsigned     CW      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Counter clears on reaching CNT_MAX, so it can never wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= ~level;
                press <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/io_sequencer.sv
// IN/OUT sequencer: stalls the core for a debounced switch entry and latches OUT values.
module io_sequencer
    import io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SW_WIDTH        = SW_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    io_sequencer_if.slave  bus
);

    io_state_t           state;
    io_state_t           state_n;
    logic [SW_WIDTH-1:0] sw_sync1;
    logic [SW_WIDTH-1:0] sw_sync2;
    logic [IO_WORD-1:0]  sw_word;
    logic [IO_WORD-1:0]  in_data_q;
    logic [IO_WORD-1:0]  display_q;
    logic                display_valid_q;
    logic                echo_q;
    logic                btn_level;
    logic                btn_press;
    logic                capture_en;
    logic                stall;
    logic                sel_in;
    logic                reg_write_in;
    logic                waiting;

    btn_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock (clock),
        .reset (reset),
        .btn   (bus.btn_enter),
        .level (btn_level),
        .press (btn_press)
    );

    assign sw_word = IO_WORD'(sw_sync2);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n      = state;
        stall        = 1'b0;
        sel_in       = 1'b0;
        reg_write_in = 1'b0;
        waiting      = 1'b0;
        capture_en   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_req) begin
                    stall   = 1'b1;
                    state_n = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                stall   = 1'b1;
                waiting = 1'b1;
                if (!btn_level) begin
                    state_n = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                stall   = 1'b1;
                waiting = 1'b1;
                if (btn_press) begin
                    capture_en = 1'b1;
                    state_n    = CAPTURE;
                end
            end
            CAPTURE: begin
                sel_in       = 1'b1;
                reg_write_in = 1'b1;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Echo display is loaded on entry to CAPTURE so it is visible alongside reg_write_in.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_sync1        <= '0;
            sw_sync2        <= '0;
            in_data_q       <= '0;
            display_q       <= '0;
            display_valid_q <= 1'b0;
            echo_q          <= 1'b0;
        end else begin
            sw_sync1 <= bus.switches;
            sw_sync2 <= sw_sync1;
            if (state == IDLE) begin
                if (bus.in_req) begin
                    echo_q <= bus.out_req;
                end else if (bus.out_req) begin
                    display_q       <= bus.out_data;
                    display_valid_q <= 1'b1;
                end
            end
            if (capture_en) begin
                in_data_q <= sw_word;
                if (echo_q) begin
                    display_q       <= sw_word;
                    display_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.stall         = stall;
    assign bus.sel_in        = sel_in;
    assign bus.reg_write_in  = reg_write_in;
    assign bus.waiting       = waiting;
    assign bus.in_data       = in_data_q;
    assign bus.display       = display_q;
    assign bus.display_valid = display_valid_q;

endmodule

// File: tb/tb_io_sequencer.sv
// Scoreboard bench for io_sequencer with a short debounce window.
module tb_io_sequencer;

    localparam int unsigned DEB = 4;
    localparam int unsigned SW  = 17;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int tests     = 0;
    int fails     = 0;
    int rwi_count = 0;
    logic [31:0] exp_q[$];

    io_sequencer_if #(.SW_WIDTH(SW)) bus ();

    io_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .SW_WIDTH(SW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Steps until reg_write_in is seen; the control unit then retires the instruction.
    task automatic wait_capture(input int budget, output int n);
        bit seen = 1'b0;
        n = 0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            n++;
            if (bus.reg_write_in === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("capture_timeout", 32'd0, 32'd1);
        end else begin
            bus.in_req  = 1'b0;
            bus.out_req = 1'b0;
        end
    endtask

    always @(negedge clock) begin
        if (!reset && bus.reg_write_in === 1'b1) begin
            rwi_count++;
            if (exp_q.size() == 0) begin
                check("rwi_unexpected", 32'd1, 32'd0);
            end else begin
                check("in_data", bus.in_data, exp_q.pop_front());
            end
            check("cap_sel_in", {31'd0, bus.sel_in}, 32'd1);
            check("cap_stall", {31'd0, bus.stall}, 32'd0);
        end
    end

    initial begin
        int n;
        int base;
        bus.in_req    = 1'b0;
        bus.out_req   = 1'b0;
        bus.switches  = '0;
        bus.btn_enter = 1'b0;
        bus.out_data  = '0;
        tick(2);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_waiting", {31'd0, bus.waiting}, 32'd0);
        check("rst_rwi", {31'd0, bus.reg_write_in}, 32'd0);
        check("rst_sel_in", {31'd0, bus.sel_in}, 32'd0);
        check("rst_valid", {31'd0, bus.display_valid}, 32'd0);
        check("rst_display", bus.display, 32'd0);
        check("rst_in_data", bus.in_data, 32'd0);
        reset = 1'b0;
        tick(3);

        // OUT only
        bus.out_req  = 1'b1;
        bus.out_data = 32'hDEADBEEF;
        #1;
        check("out_stall_req", {31'd0, bus.stall}, 32'd0);
        tick(1);
        bus.out_req = 1'b0;
        check("out_display", bus.display, 32'hDEADBEEF);
        check("out_valid", {31'd0, bus.display_valid}, 32'd1);
        check("out_stall_after", {31'd0, bus.stall}, 32'd0);

        // IN with a clean press
        bus.switches = 17'h1ABCD;
        tick(1);
        bus.in_req = 1'b1;
        #1;
        check("in_stall_same_cycle", {31'd0, bus.stall}, 32'd1);
        tick(4);
        check("in_waiting", {31'd0, bus.waiting}, 32'd1);
        check("in_stall_wait", {31'd0, bus.stall}, 32'd1);
        exp_q.push_back(32'h0001ABCD);
        bus.btn_enter = 1'b1;
        wait_capture(30, n);
        check("press_latency", {31'd0, (n >= 6 && n <= 7)}, 32'd1);
        check("cap_in_data", bus.in_data, 32'h0001ABCD);
        bus.switches = 17'h00FFF;
        tick(1);
        check("post_cap_rwi", {31'd0, bus.reg_write_in}, 32'd0);
        check("post_cap_sel", {31'd0, bus.sel_in}, 32'd0);
        check("post_cap_stall", {31'd0, bus.stall}, 32'd0);
        check("in_data_hold", bus.in_data, 32'h0001ABCD);
        check("no_echo_display", bus.display, 32'hDEADBEEF);

        // Bouncing button
        bus.btn_enter = 1'b0;
        tick(10);
        base = rwi_count;
        bus.switches = 17'h0BEEF;
        bus.in_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.btn_enter = 1'b1;
            tick(2);
            bus.btn_enter = 1'b0;
            tick(2);
        end
        check("bounce_no_capture", rwi_count, base);
        check("bounce_waiting", {31'd0, bus.waiting}, 32'd1);
        exp_q.push_back(32'h0000BEEF);
        bus.btn_enter = 1'b1;
        wait_capture(30, n);
        tick(5);
        check("bounce_one_pulse", rwi_count, base + 1);

        // Button still held across a second IN
        bus.switches = 17'h1FFFF;
        bus.in_req = 1'b1;
        tick(15);
        check("held_waiting", {31'd0, bus.waiting}, 32'd1);
        check("held_stall", {31'd0, bus.stall}, 32'd1);
        check("held_no_capture", rwi_count, base + 1);
        bus.btn_enter = 1'b0;
        tick(8);
        check("held_after_release", {31'd0, bus.waiting}, 32'd1);
        bus.switches = 17'h05555;
        tick(3);
        exp_q.push_back(32'h00005555);
        bus.btn_enter = 1'b1;
        wait_capture(30, n);
        tick(1);
        check("held_in_data", bus.in_data, 32'h00005555);

        // IN with echo
        bus.btn_enter = 1'b0;
        tick(8);
        bus.switches = 17'h00042;
        bus.in_req  = 1'b1;
        bus.out_req = 1'b1;
        tick(1);
        check("echo_no_entry_update", bus.display, 32'hDEADBEEF);
        tick(6);
        exp_q.push_back(32'h00000042);
        bus.btn_enter = 1'b1;
        wait_capture(30, n);
        check("echo_display", bus.display, 32'h00000042);
        check("echo_valid", {31'd0, bus.display_valid}, 32'd1);
        check("echo_rwi", {31'd0, bus.reg_write_in}, 32'd1);

        // Reset while waiting for the press
        bus.btn_enter = 1'b0;
        tick(8);
        bus.in_req  = 1'b1;
        bus.out_req = 1'b1;
        tick(8);
        check("pre_reset_waiting", {31'd0, bus.waiting}, 32'd1);
        base = rwi_count;
        #2;
        reset       = 1'b1;
        bus.in_req  = 1'b0;
        bus.out_req = 1'b0;
        #1;
        check("mid_reset_stall", {31'd0, bus.stall}, 32'd0);
        check("mid_reset_waiting", {31'd0, bus.waiting}, 32'd0);
        check("mid_reset_display", bus.display, 32'd0);
        check("mid_reset_valid", {31'd0, bus.display_valid}, 32'd0);
        check("mid_reset_in_data", bus.in_data, 32'd0);
        tick(2);
        reset = 1'b0;
        bus.btn_enter = 1'b1;
        tick(10);
        bus.btn_enter = 1'b0;
        tick(10);
        check("idle_press_ignored", rwi_count, base);
        check("post_reset_stall", {31'd0, bus.stall}, 32'd0);
        check("post_reset_waiting", {31'd0, bus.waiting}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
